// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and defaults for the CPU bus arbiter.
package cpu_bus_arbiter_pkg;

  // Bus ownership state; TURN is the dead cycle between owners.
  typedef enum logic [1:0] {
    OWN_IE  = 2'd0,
    OWN_IH  = 2'd1,
    OWN_DMA = 2'd2,
    TURN    = 2'd3
  } owner_e;

  // Master identifiers, also used as the pending-owner code during TURN.
  typedef enum logic [1:0] {
    M_NONE = 2'd0,
    M_IE   = 2'd1,
    M_IH   = 2'd2,
    M_DMA  = 2'd3
  } master_e;

  localparam int TURNAROUND_DEF = 1;
  localparam int DMA_ALIGN_DEF  = 1;

  // Ownership state that a master occupies once granted.
  function automatic owner_e own_of(input master_e m);
    case (m)
      M_IH:    return OWN_IH;
      M_DMA:   return OWN_DMA;
      default: return OWN_IE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Master-side and memory-side signals of the shared CPU bus.
interface cpu_bus_arbiter_if;
  logic [15:0] ie_addr;
  logic [7:0]  ie_dout;
  logic        ie_we;
  logic        ie_halt;
  logic        ih_req;
  logic [15:0] ih_addr;
  logic [7:0]  ih_dout;
  logic        ih_we;
  logic        ih_halt;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        dma_grant;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [7:0]  bus_din;

  // The masters' view: drive requests, see halts/grant and read data.
  modport master (
    output ie_addr, ie_dout, ie_we, ih_req, ih_addr, ih_dout, ih_we,
           dma_req, dma_addr, dma_dout, dma_we,
    input  ie_halt, ih_halt, dma_grant, bus_din
  );

  // The arbiter's view.
  modport slave (
    input  ie_addr, ie_dout, ie_we, ih_req, ih_addr, ih_dout, ih_we,
           dma_req, dma_addr, dma_dout, dma_we,
    output ie_halt, ih_halt, dma_grant, bus_addr, bus_dout, bus_we
  );

  // The memory map's view; read data goes straight back to every master.
  modport mem (
    input  bus_addr, bus_dout, bus_we,
    output bus_din
  );
endinterface

// File: rtl/cpu_bus_arbiter_mux.sv
// Combinational 3:1 bus mux with an idle override used on turnaround cycles.
module cpu_bus_arbiter_mux
  import cpu_bus_arbiter_pkg::*;
(
  input  master_e     i_sel,
  input  logic        i_force_idle,
  input  logic [15:0] i_idle_addr,
  input  logic [15:0] i_ie_addr,
  input  logic [7:0]  i_ie_dout,
  input  logic        i_ie_we,
  input  logic [15:0] i_ih_addr,
  input  logic [7:0]  i_ih_dout,
  input  logic        i_ih_we,
  input  logic [15:0] i_dma_addr,
  input  logic [7:0]  i_dma_dout,
  input  logic        i_dma_we,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dout,
  output logic        o_we
);

  // Pick the owner's signals; idle holds the address and blocks writes.
  always_comb begin
    o_addr = i_ie_addr;
    o_dout = i_ie_dout;
    o_we   = i_ie_we;
    if (i_force_idle) begin
      o_addr = i_idle_addr;
      o_dout = 8'h00;
      o_we   = 1'b0;
    end else begin
      case (i_sel)
        M_IH: begin
          o_addr = i_ih_addr;
          o_dout = i_ih_dout;
          o_we   = i_ih_we;
        end
        M_DMA: begin
          o_addr = i_dma_addr;
          o_dout = i_dma_dout;
          o_we   = i_dma_we;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Ownership FSM for the CPU memory bus shared by IE, IH and OAM DMA.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int TURNAROUND = TURNAROUND_DEF,
  parameter int DMA_ALIGN  = DMA_ALIGN_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cpu_bus_arbiter_if.slave  bus
);

  owner_e      r_state;
  master_e     r_pend;
  logic        r_cyc_par;
  logic [15:0] r_last_addr;

  master_e     w_tgt;
  master_e     w_sel;
  logic        w_dma_wait;
  logic [15:0] w_bus_addr;

  // Next owner requested at this edge; M_NONE means keep the current state.
  always_comb begin
    w_tgt = M_NONE;
    case (r_state)
      OWN_IE: begin
        if (bus.ih_req)       w_tgt = M_IH;
        else if (bus.dma_req) w_tgt = M_DMA;
      end
      OWN_IH:
        if (!bus.ih_req) w_tgt = bus.dma_req ? M_DMA : M_IE;
      OWN_DMA:
        if (!bus.dma_req) w_tgt = bus.ih_req ? M_IH : M_IE;
      default: begin
        // A pending master that dropped its request is abandoned.
        case (r_pend)
          M_IH:    w_tgt = bus.ih_req  ? M_IH  : (bus.dma_req ? M_DMA : M_IE);
          M_DMA:   w_tgt = bus.dma_req ? M_DMA : (bus.ih_req  ? M_IH  : M_IE);
          default: w_tgt = M_IE;
        endcase
      end
    endcase
    // DMA may only start on an even cycle, i.e. when the parity is odd now.
    w_dma_wait = (DMA_ALIGN != 0) && (w_tgt == M_DMA) && !r_cyc_par;
  end

  // Ownership state, cycle parity and the address held during turnaround.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= OWN_IE;
      r_pend      <= M_NONE;
      r_cyc_par   <= 1'b0;
      r_last_addr <= 16'h0000;
    end else begin
      r_cyc_par   <= ~r_cyc_par;
      r_last_addr <= w_bus_addr;
      if (w_tgt != M_NONE) begin
        if ((r_state == TURN) || (TURNAROUND == 0)) begin
          if (w_dma_wait) begin
            r_state <= TURN;
            r_pend  <= M_DMA;
          end else begin
            r_state <= own_of(w_tgt);
            r_pend  <= M_NONE;
          end
        end else begin
          r_state <= TURN;
          r_pend  <= w_tgt;
        end
      end
    end
  end

  // Mux select follows the registered owner.
  always_comb begin
    case (r_state)
      OWN_IH:  w_sel = M_IH;
      OWN_DMA: w_sel = M_DMA;
      default: w_sel = M_IE;
    endcase
  end

  cpu_bus_arbiter_mux u_mux (
    .i_sel        (w_sel),
    .i_force_idle (r_state == TURN),
    .i_idle_addr  (r_last_addr),
    .i_ie_addr    (bus.ie_addr),
    .i_ie_dout    (bus.ie_dout),
    .i_ie_we      (bus.ie_we),
    .i_ih_addr    (bus.ih_addr),
    .i_ih_dout    (bus.ih_dout),
    .i_ih_we      (bus.ih_we),
    .i_dma_addr   (bus.dma_addr),
    .i_dma_dout   (bus.dma_dout),
    .i_dma_we     (bus.dma_we),
    .o_addr       (w_bus_addr),
    .o_dout       (bus.bus_dout),
    .o_we         (bus.bus_we)
  );

  assign bus.bus_addr  = w_bus_addr;
  assign bus.ie_halt   = (r_state != OWN_IE);
  assign bus.ih_halt   = bus.ih_req && (r_state != OWN_IH);
  assign bus.dma_grant = (r_state == OWN_DMA);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: one expected bus snapshot per cycle.
module tb_cpu_bus_arbiter;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic        ie_halt;
    logic        ih_halt;
    logic        dma_grant;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  string tag_q[$];

  cpu_bus_arbiter_if u_if();

  cpu_bus_arbiter u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push the expected outputs for the current cycle, then advance one cycle.
  task automatic step(input string tag, input logic [15:0] a, input logic [7:0] d,
                      input logic we, input logic ieh, input logic ihh, input logic dg);
    exp_t e;
    e.addr = a; e.dout = d; e.we = we;
    e.ie_halt = ieh; e.ih_halt = ihh; e.dma_grant = dg;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Compare mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, "_addr"},  {16'h0, u_if.bus_addr},  {16'h0, e.addr});
      chk({t, "_dout"},  {24'h0, u_if.bus_dout},  {24'h0, e.dout});
      chk({t, "_we"},    {31'h0, u_if.bus_we},    {31'h0, e.we});
      chk({t, "_ieh"},   {31'h0, u_if.ie_halt},   {31'h0, e.ie_halt});
      chk({t, "_ihh"},   {31'h0, u_if.ih_halt},   {31'h0, e.ih_halt});
      chk({t, "_grant"}, {31'h0, u_if.dma_grant}, {31'h0, e.dma_grant});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    u_if.ie_addr  = 16'h8000; u_if.ie_dout  = 8'h11; u_if.ie_we  = 1'b0;
    u_if.ih_req   = 1'b0;
    u_if.ih_addr  = 16'h01FD; u_if.ih_dout  = 8'h22; u_if.ih_we  = 1'b1;
    u_if.dma_req  = 1'b0;
    u_if.dma_addr = 16'hFE00; u_if.dma_dout = 8'h33; u_if.dma_we = 1'b1;
    u_if.bus_din  = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state: IE owns the bus
    step("rst",        16'h8000, 8'h11, 0, 0, 0, 0);
    // IH request with one turnaround cycle
    u_if.ih_req = 1'b1;
    step("t2_req",     16'h8000, 8'h11, 0, 0, 1, 0);
    step("t2_turn",    16'h8000, 8'h00, 0, 1, 1, 0);
    step("t2_own",     16'h01FD, 8'h22, 1, 1, 0, 0);
    u_if.ih_req = 1'b0;
    step("t2_rel",     16'h01FD, 8'h22, 1, 1, 0, 0);
    step("t2_turn_ie", 16'h01FD, 8'h00, 0, 1, 0, 0);
    // simultaneous IH and DMA: IH first, then DMA with no IE slot
    u_if.ih_req = 1'b1; u_if.dma_req = 1'b1;
    step("t3_req",     16'h8000, 8'h11, 0, 0, 1, 0);
    step("t3_turn",    16'h8000, 8'h00, 0, 1, 1, 0);
    u_if.ih_req = 1'b0;
    step("t3_ih",      16'h01FD, 8'h22, 1, 1, 0, 0);
    step("t3_turn_d",  16'h01FD, 8'h00, 0, 1, 0, 0);
    // DMA owner: only dma_we reaches the bus
    u_if.ie_we = 1'b1;
    step("t5_we1",     16'hFE00, 8'h33, 1, 1, 0, 1);
    u_if.dma_we = 1'b0;
    step("t5_we0",     16'hFE00, 8'h33, 0, 1, 0, 1);
    u_if.ie_we = 1'b0; u_if.ih_we = 1'b0; u_if.dma_we = 1'b1;
    step("t5_we1b",    16'hFE00, 8'h33, 1, 1, 0, 1);
    u_if.dma_req = 1'b0; u_if.ie_we = 1'b1;
    step("t5_rel",     16'hFE00, 8'h33, 1, 1, 0, 1);
    u_if.ie_we = 1'b0; u_if.ih_we = 1'b1;
    step("t5_turn",    16'hFE00, 8'h00, 0, 1, 0, 0);
    // DMA request whose turnaround would end on an odd cycle: extra TURN
    u_if.dma_req = 1'b1;
    step("t4_req",     16'h8000, 8'h11, 0, 0, 0, 0);
    step("t4_turn1",   16'h8000, 8'h00, 0, 1, 0, 0);
    step("t4_turn2",   16'h8000, 8'h00, 0, 1, 0, 0);
    u_if.dma_req = 1'b0;
    step("t4_grant",   16'hFE00, 8'h33, 1, 1, 0, 1);
    step("t4_turn_ie", 16'hFE00, 8'h00, 0, 1, 0, 0);
    // reset while IH owns the bus
    u_if.ih_req = 1'b1;
    step("t6_ie",      16'h8000, 8'h11, 0, 0, 1, 0);
    step("t6_turn",    16'h8000, 8'h00, 0, 1, 1, 0);
    rst = 1'b1; u_if.ie_we = 1'b1;
    step("t6_ih",      16'h01FD, 8'h22, 1, 1, 0, 0);
    rst = 1'b0;
    step("t6_rst",     16'h8000, 8'h11, 1, 0, 1, 0);
    // pending IH drops its request during TURN: back to IE
    u_if.ie_we = 1'b0; u_if.ih_req = 1'b0;
    step("drop_turn",  16'h8000, 8'h00, 0, 1, 0, 0);
    step("drop_ie",    16'h8000, 8'h11, 0, 0, 0, 0);

    chk("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
